// File: rtl/fifox_rd_pkg.sv
// Shared definitions for the FIFOX read-side MVB adapter.
package fifox_rd_pkg;

    // Skid buffer occupancy: empty, head only, head plus overflow.
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry registered skid buffer; head_reg always drives dout, second_reg
// absorbs the one item that can arrive while the consumer stalls.
module skid_buf2
    import fifox_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  vld,
    output buf_state_t            state
);

    buf_state_t            state_reg, state_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic [DATA_WIDTH-1:0] second_reg, second_next;
    logic                  vld_reg;

    always_comb begin
        state_next  = state_reg;
        head_next   = head_reg;
        second_next = second_reg;
        case (state_reg)
            S0: begin
                if (push) begin
                    head_next  = din;
                    state_next = S1;
                end
            end
            S1: begin
                if (push && pop) begin
                    head_next = din;
                end else if (push) begin
                    second_next = din;
                    state_next  = S2;
                end else if (pop) begin
                    state_next = S0;
                end
            end
            S2: begin
                // The upstream read is blocked here, so only a pop can occur.
                if (pop) begin
                    head_next  = second_reg;
                    state_next = S1;
                end
            end
            default: state_next = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= S0;
            head_reg   <= '0;
            second_reg <= '0;
            vld_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            head_reg   <= head_next;
            second_reg <= second_next;
            vld_reg    <= (state_next != S0);
        end
    end

    assign dout  = head_reg;
    assign vld   = vld_reg;
    assign state = state_reg;

endmodule

// File: rtl/fifox_rd_mvb.sv
// Show-ahead FIFOX reader presenting a single-item MVB stream with registered
// outputs, plus a saturating count of delivered items.
module fifox_rd_mvb
    import fifox_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_do,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_vld,
    output logic                  tx_src_rdy,
    input  logic                  tx_dst_rdy,
    input  logic                  cnt_clr,
    output logic [CNT_WIDTH-1:0]  cnt_items
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    buf_state_t           buf_state;
    logic                 buf_vld;
    logic                 push;
    logic                 pop;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;

    // Read enable looks only at registered buffer state, never at tx_dst_rdy,
    // which is what keeps the consumer's ready off the FIFO read path.
    assign fifo_rd = ~reset & ~fifo_empty & (buf_state != S2);
    assign push    = fifo_rd & ~fifo_empty;
    assign pop     = buf_vld & tx_dst_rdy;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) skid_buf2_i (
        .clk   (clk),
        .srst  (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_do),
        .dout  (tx_data),
        .vld   (buf_vld),
        .state (buf_state)
    );

    assign tx_src_rdy = buf_vld;
    assign tx_vld     = buf_vld;

    always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clr) begin
            cnt_next = pop ? CNT_ONE : '0;
        end else if (pop && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_items = cnt_reg;

endmodule

// File: tb/tb_fifox_rd_mvb.sv
// Bench for fifox_rd_mvb: queue-based FIFO environment, occupancy/scoreboard
// reference model, two DUTs differing only in counter width.
module tb_fifox_rd_mvb;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_do = '0;
    logic          tx_dst_rdy = 1'b0;
    logic          cnt_clr = 1'b0;

    logic          fifo_rd, tx_vld, tx_src_rdy;
    logic [DW-1:0] tx_data;
    logic [31:0]   cnt_w;

    logic          fifo_rd_n, tx_vld_n, tx_src_rdy_n;
    logic [DW-1:0] tx_data_n;
    logic [3:0]    cnt_n;

    always #5 clk = ~clk;

    fifox_rd_mvb #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut_w (
        .clk        (clk),
        .reset      (reset),
        .fifo_do    (fifo_do),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .tx_data    (tx_data),
        .tx_vld     (tx_vld),
        .tx_src_rdy (tx_src_rdy),
        .tx_dst_rdy (tx_dst_rdy),
        .cnt_clr    (cnt_clr),
        .cnt_items  (cnt_w)
    );

    fifox_rd_mvb #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_n (
        .clk        (clk),
        .reset      (reset),
        .fifo_do    (fifo_do),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd_n),
        .tx_data    (tx_data_n),
        .tx_vld     (tx_vld_n),
        .tx_src_rdy (tx_src_rdy_n),
        .tx_dst_rdy (tx_dst_rdy),
        .cnt_clr    (cnt_clr),
        .cnt_items  (cnt_n)
    );

    // Environment FIFO contents and reference model state.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] sb[$];
    int            occ = 0;
    longint        exp_w = 0;
    int            exp_n = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            n_tx = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    // One clock cycle: drive inputs, check outputs against the model, then
    // advance the model by what happens at the rising edge.
    task automatic cycle(input bit rdy, input bit clr, input bit rst);
        bit            exp_rd, exp_vld, do_push, do_pop;
        logic [DW-1:0] item;
        reset      = rst;
        tx_dst_rdy = rdy;
        cnt_clr    = clr;
        fifo_empty = (fifo_q.size() == 0);
        fifo_do    = fifo_empty ? '0 : fifo_q[0];
        #1;
        exp_rd  = !rst && (fifo_q.size() != 0) && (occ < 2);
        exp_vld = (occ > 0);
        n_tests++;
        if (fifo_rd !== exp_rd) begin
            n_fail++;
            $display("FAIL fifo_rd: got %b expected %b (occ %0d)", fifo_rd, exp_rd, occ);
        end
        n_tests++;
        if (tx_src_rdy !== exp_vld || tx_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL tx_src_rdy/tx_vld: got %b/%b expected %b", tx_src_rdy, tx_vld, exp_vld);
        end
        if (exp_vld) begin
            n_tests++;
            if (tx_data !== sb[0]) begin
                n_fail++;
                $display("FAIL tx_data order: got %h expected %h", tx_data, sb[0]);
            end
        end
        if (stall_prev && exp_vld) begin
            n_tests++;
            if (tx_data !== data_prev) begin
                n_fail++;
                $display("FAIL tx_data stable under stall: got %h expected %h", tx_data, data_prev);
            end
        end
        n_tests++;
        if (cnt_w !== exp_w[31:0] || cnt_n !== exp_n[3:0]) begin
            n_fail++;
            $display("FAIL cnt_items: got %0d/%0d expected %0d/%0d", cnt_w, cnt_n, exp_w, exp_n);
        end
        do_push    = (fifo_rd === 1'b1) && !fifo_empty;
        do_pop     = exp_vld && rdy;
        stall_prev = exp_vld && !rdy;
        data_prev  = tx_data;
        if (do_pop)
            $display("[TB] tx item %h cnt %0d", tx_data, cnt_w);
        @(posedge clk);
        item = '0;
        if (do_push) item = fifo_q.pop_front();
        if (rst) begin
            occ = 0;
            sb.delete();
            exp_w = 0;
            exp_n = 0;
            stall_prev = 1'b0;
        end else begin
            if (do_pop) begin
                void'(sb.pop_front());
                occ--;
                n_tx++;
            end
            if (do_push) begin
                sb.push_back(item);
                occ++;
            end
            if (clr) begin
                exp_w = do_pop ? 1 : 0;
                exp_n = do_pop ? 1 : 0;
            end else if (do_pop) begin
                exp_w = exp_w + 1;
                exp_n = (exp_n < 15) ? exp_n + 1 : 15;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int rdy_pct, input int budget);
        int b = budget;
        while ((fifo_q.size() != 0 || occ != 0) && b > 0) begin
            cycle($urandom_range(99) < rdy_pct, 1'b0, 1'b0);
            b--;
        end
        n_tests++;
        if (fifo_q.size() != 0 || occ != 0) begin
            n_fail++;
            $display("FAIL drain timeout: fifo %0d buffered %0d remaining, expected 0", fifo_q.size(), occ);
        end
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(DW'(i));
        reset = 1'b1;
        fifo_empty = 1'b0;
        fifo_do = fifo_q[0];
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1);
            n_tests++;
            if (tx_data !== '0) begin
                n_fail++;
                $display("FAIL reset tx_data: got %h expected 0", tx_data);
            end
        end
    endtask

    task automatic test_streaming();
        int tx0 = n_tx;
        drain(100, 40);
        n_tests++;
        if (n_tx - tx0 != 16 || cnt_w !== 32'd16 || cnt_n !== 4'd15) begin
            n_fail++;
            $display("FAIL streaming: got %0d items cnt %0d/%0d expected 16 items cnt 16/15",
                     n_tx - tx0, cnt_w, cnt_n);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) fifo_q.push_back(DW'(16'hA0 + i));
        drain(50, 300);
    endtask

    task automatic test_single();
        int tx0 = n_tx;
        fifo_q.push_back(DW'(16'h55));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (n_tx - tx0 != 1 || tx_src_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL single item: got %0d transfers src_rdy %b expected 1 transfer src_rdy 0",
                     n_tx - tx0, tx_src_rdy);
        end
    endtask

    task automatic test_counter();
        int b = 10;
        cycle(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) fifo_q.push_back(DW'($urandom));
        drain(100, 60);
        n_tests++;
        if (cnt_n !== 4'd15 || cnt_w !== 32'd20) begin
            n_fail++;
            $display("FAIL counter saturation: got %0d/%0d expected 20/15", cnt_w, cnt_n);
        end
        for (int i = 0; i < 3; i++) fifo_q.push_back(DW'($urandom));
        while (occ == 0 && b > 0) begin
            cycle(1'b1, 1'b0, 1'b0);
            b--;
        end
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        n_tests++;
        if (cnt_w !== 32'd1 || cnt_n !== 4'd1) begin
            n_fail++;
            $display("FAIL counter clear with transfer: got %0d/%0d expected 1/1", cnt_w, cnt_n);
        end
        drain(100, 20);
    endtask

    task automatic test_reset_mid();
        int b = 10;
        for (int i = 0; i < 8; i++) fifo_q.push_back(DW'(16'hC0 + i));
        while (occ < 2 && b > 0) begin
            cycle(1'b0, 1'b0, 1'b0);
            b--;
        end
        n_tests++;
        if (occ != 2 || fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL fill to full: got occ %0d fifo_rd %b expected 2 / 0", occ, fifo_rd);
        end
        cycle(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (tx_src_rdy !== 1'b0 || fifo_q.size() != 6) begin
            n_fail++;
            $display("FAIL reset mid-stream: got src_rdy %b fifo %0d expected 0 / 6",
                     tx_src_rdy, fifo_q.size());
        end
        drain(70, 80);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_single();
        test_counter();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifox_rd_mvb.md
# fifox_rd_mvb

Reader-side adapter for a show-ahead FIFOX: pops items from the FIFO read port and presents them as a single-item MVB transmit stream with fully registered outputs. Breaks the combinational path from downstream `DST_RDY` to the FIFO `RD` input by means of a 2-entry skid buffer, sustaining one item per cycle. Also keeps a saturating count of delivered items. Sits between a FIFOX instance and any MVB consumer; it is the counterpart to the FIFOX write-side adapter.

## Interface
Parameters:
- DATA_WIDTH, 64, width of one item
- CNT_WIDTH, 32, width of delivered-item counter

Ports:
- CLK  in  1  single clock, all logic rising-edge
- RESET  in  1  synchronous, active-high reset
- FIFO_DO  in  DATA_WIDTH  FIFO head item, valid when FIFO_EMPTY=0
- FIFO_EMPTY  in  1  FIFO empty flag
- FIFO_RD  out  1  pop request; pop occurs when FIFO_RD=1 and FIFO_EMPTY=0
- TX_DATA  out  DATA_WIDTH  MVB item data
- TX_VLD  out  1  item valid, equals TX_SRC_RDY
- TX_SRC_RDY  out  1  item available
- TX_DST_RDY  in  1  consumer ready; transfer when TX_SRC_RDY=1 and TX_DST_RDY=1
- CNT_CLR  in  1  synchronous clear of counter
- CNT_ITEMS  out  CNT_WIDTH  number of completed TX transfers, saturating

## Operation
- Buffer occupancy state: S0 (empty), S1 (one item), S2 (full). Head register drives TX_DATA; second register holds overflow item.
- push = FIFO_RD & ~FIFO_EMPTY; pop = TX_SRC_RDY & TX_DST_RDY.
- FIFO_RD = ~RESET & ~FIFO_EMPTY & (state != S2). Depends only on registered state and FIFO_EMPTY; never on TX_DST_RDY.
- Transitions: S0 + push -> S1 (item into head). S1 + push & ~pop -> S2 (item into second). S1 + push & pop -> S1 (new item into head). S1 + pop & ~push -> S0. S2 + pop -> S1 (second moves to head). S2 never pushes. Other cases hold.
- TX_SRC_RDY = TX_VLD = (state != S0), registered.
- Order strictly preserved; no item dropped or duplicated.
- TX_DATA stable while TX_SRC_RDY=1 and TX_DST_RDY=0.
- Counter: +1 per pop, saturates at 2^CNT_WIDTH-1. CNT_CLR and pop in same cycle -> CNT_ITEMS=1 next cycle; CNT_CLR alone -> 0.

## Timing
- Reset values: state S0, TX_SRC_RDY=0, TX_VLD=0, TX_DATA=0, CNT_ITEMS=0, FIFO_RD=0 while RESET=1.
- Reset mid-operation: buffered items discarded; FIFO not popped during reset cycle.
- Latency: FIFO item popped in cycle t appears on TX at t+1.
- Throughput: 1 item/cycle with TX_DST_RDY held 1 (steady state S1).
- Backpressure: TX_DST_RDY low for one cycle moves S1 -> S2; FIFO_RD drops the following cycle; restart costs no bubble.
- FIFO_EMPTY rising while in S1 with pop -> S0, TX_SRC_RDY=0 next cycle.

## Structure
- Shared package fifox_rd_pkg: state enum (S0, S1, S2).
- One sub-module: skid_buf2 (2-entry registered buffer with push/pop/state, parameter DATA_WIDTH); top adds FIFO_RD logic and counter.

## Test plan
- Reset: RESET=1 for 3 cycles with FIFO_EMPTY=0 -> FIFO_RD=0, TX_SRC_RDY=0, CNT_ITEMS=0 throughout.
- Streaming: FIFO holds 0x1..0x10, TX_DST_RDY=1 -> 16 items in order on consecutive cycles starting 1 cycle after first pop, CNT_ITEMS=16.
- Backpressure: stream 0xA0..0xAF, TX_DST_RDY random 50% -> exact ordered sequence, TX_DATA stable under stall, FIFO_RD=0 whenever state S2.
- Single item: FIFO gets one item 0x55 then EMPTY -> one TX transfer, TX_SRC_RDY falls next cycle, CNT_ITEMS=1.
- Counter: CNT_WIDTH=4, 20 transfers -> CNT_ITEMS=15; CNT_CLR with concurrent transfer -> 1.
- Reset mid-stream in state S2 -> next cycle S0, buffered items lost, following items resume from FIFO head.
